// File: rtl/vga_fb_scanout_if.sv
// Bus between the VGA scanout block and its surroundings: pixel tick, bitmap RAM port
// and the video outputs.
interface vga_fb_scanout_if #(
    parameter int unsigned WORD_BITS = 16,
    parameter int unsigned ADDR_BITS = 13
);
    logic                 pix_ce;
    logic [WORD_BITS-1:0] bitmap_mem;
    logic [ADDR_BITS-1:0] bitmap_addr;
    logic                 HSyncOut;
    logic                 VSyncOut;
    logic [2:0]           Red;
    logic [2:0]           Green;
    logic [1:0]           Blue;
    logic                 frame_start;
    logic                 vblank;

    modport master (
        input  pix_ce,
        input  bitmap_mem,
        output bitmap_addr,
        output HSyncOut,
        output VSyncOut,
        output Red,
        output Green,
        output Blue,
        output frame_start,
        output vblank
    );

    modport slave (
        output pix_ce,
        output bitmap_mem,
        input  bitmap_addr,
        input  HSyncOut,
        input  VSyncOut,
        input  Red,
        input  Green,
        input  Blue,
        input  frame_start,
        input  vblank
    );
endinterface

// File: rtl/vga_fb_scanout.sv
// Parametrised VGA timing plus 1-bpp framebuffer scanout with border colour.
// Optional `VGA_PIXEL_DOUBLE_EN shows each framebuffer pixel as a 2x2 block.
module vga_fb_scanout #(
    parameter int unsigned H_DISPLAY    = 640,
    parameter int unsigned H_FRONT      = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BACK       = 48,
    parameter int unsigned V_DISPLAY    = 480,
    parameter int unsigned V_FRONT      = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BACK       = 33,
    parameter bit          SYNC_ACTIVE  = 1'b0,
    parameter int unsigned FB_WIDTH     = 512,
    parameter int unsigned FB_HEIGHT    = 256,
    parameter int unsigned FB_X0        = 64,
    parameter int unsigned FB_Y0        = 112,
    parameter int unsigned WORD_BITS    = 16,
    parameter int unsigned ADDR_BITS    = 13,
    parameter logic [7:0]  FG_COLOR     = 8'h00,
    parameter logic [7:0]  BG_COLOR     = 8'hFF,
    parameter logic [7:0]  BORDER_COLOR = 8'h03
) (
    input logic               clk,
    input logic               reset,
    vga_fb_scanout_if.master  bus
);
    localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned BIW      = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned WORDS_PER_LINE = FB_WIDTH / WORD_BITS;
`ifdef VGA_PIXEL_DOUBLE_EN
    localparam int unsigned FB_SPAN_W = 2 * FB_WIDTH;
    localparam int unsigned FB_SPAN_H = 2 * FB_HEIGHT;
`else
    localparam int unsigned FB_SPAN_W = FB_WIDTH;
    localparam int unsigned FB_SPAN_H = FB_HEIGHT;
`endif
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    // Elaboration-time legality checks on the parameter set.
    if (FB_X0 + FB_SPAN_W > H_DISPLAY || FB_Y0 + FB_SPAN_H > V_DISPLAY) begin : g_bad_fb_place
        $error("vga_fb_scanout: framebuffer does not fit inside the display area");
    end
    if (FB_WIDTH % WORD_BITS != 0) begin : g_bad_fb_width
        $error("vga_fb_scanout: FB_WIDTH must be a multiple of WORD_BITS");
    end
    if (WORDS_PER_LINE * FB_HEIGHT > (1 << ADDR_BITS)) begin : g_bad_addr_bits
        $error("vga_fb_scanout: ADDR_BITS too narrow for the framebuffer");
    end

    // Stage 0: raster counters.
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          wrap0_q;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
            h_d = h_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q     <= '0;
            v_q     <= '0;
            wrap0_q <= 1'b0;
        end else if (bus.pix_ce) begin
            h_q     <= h_d;
            v_q     <= v_d;
            // Marks a (0,0) reached by wrapping, not by reset.
            wrap0_q <= (h_q == H_LAST) && (v_q == V_LAST);
        end
    end

    // Stage 0 decode.
    logic [31:0]          h_int, v_int, h_rel, v_rel, px, py;
    logic                 in_disp0, in_fb0, hs0, vs0, vb0;
    logic [ADDR_BITS-1:0] addr0;
    logic [BIW-1:0]       bit0;

    always_comb begin
        h_int    = 32'(h_q);
        v_int    = 32'(v_q);
        in_disp0 = (h_int < H_DISPLAY) && (v_int < V_DISPLAY);
        in_fb0   = (h_int >= FB_X0) && (h_int < FB_X0 + FB_SPAN_W) &&
                   (v_int >= FB_Y0) && (v_int < FB_Y0 + FB_SPAN_H);
        hs0      = (h_int >= HS_START) && (h_int < HS_END);
        vs0      = (v_int >= VS_START) && (v_int < VS_END);
        vb0      = (v_int >= V_DISPLAY);
        h_rel    = h_int - FB_X0;
        v_rel    = v_int - FB_Y0;
`ifdef VGA_PIXEL_DOUBLE_EN
        px       = h_rel >> 1;
        py       = v_rel >> 1;
`else
        px       = h_rel;
        py       = v_rel;
`endif
        addr0    = ADDR_BITS'(py * WORDS_PER_LINE + px / WORD_BITS);
        bit0     = BIW'(px % WORD_BITS);
    end

    // Stage 1: decoded position and memory address.
    logic                 in_disp1_q, in_fb1_q, hs1_q, vs1_q, vb1_q, wrap1_q;
    logic [BIW-1:0]       bit1_q;
    logic [ADDR_BITS-1:0] addr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_disp1_q <= 1'b0;
            in_fb1_q   <= 1'b0;
            hs1_q      <= 1'b0;
            vs1_q      <= 1'b0;
            vb1_q      <= 1'b0;
            wrap1_q    <= 1'b0;
            bit1_q     <= '0;
            addr_q     <= '0;
        end else if (bus.pix_ce) begin
            in_disp1_q <= in_disp0;
            in_fb1_q   <= in_fb0;
            hs1_q      <= hs0;
            vs1_q      <= vs0;
            vb1_q      <= vb0;
            wrap1_q    <= wrap0_q;
            bit1_q     <= bit0;
            if (in_fb0) begin
                addr_q <= addr0;
            end
        end
    end

    // Stage 2: colour lookup and sync polarity.
    logic [7:0] color_d, color_q;
    logic       hsync_q, vsync_q, vblank_q, frame_start_q;

    always_comb begin
        color_d = 8'h00;
        if (in_fb1_q) begin
            color_d = bus.bitmap_mem[bit1_q] ? FG_COLOR : BG_COLOR;
        end else if (in_disp1_q) begin
            color_d = BORDER_COLOR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            color_q       <= 8'h00;
            hsync_q       <= ~SYNC_ACTIVE;
            vsync_q       <= ~SYNC_ACTIVE;
            vblank_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= bus.pix_ce && wrap1_q;
            if (bus.pix_ce) begin
                color_q  <= color_d;
                hsync_q  <= hs1_q ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                vsync_q  <= vs1_q ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                vblank_q <= vb1_q;
            end
        end
    end

    assign bus.bitmap_addr = addr_q;
    assign bus.HSyncOut    = hsync_q;
    assign bus.VSyncOut    = vsync_q;
    assign bus.Red         = color_q[7:5];
    assign bus.Green       = color_q[4:2];
    assign bus.Blue        = color_q[1:0];
    assign bus.frame_start = frame_start_q;
    assign bus.vblank      = vblank_q;
endmodule
